// File: rtl/mem_burst_ctrl.sv
// Line-granular backing memory: LATENCY wait cycles, one word per cycle, then a 1-cycle mem_valid_o pulse (LATENCY+LINE_WORDS+1 after acceptance).
// Requests are only taken in IDLE (mem_ready_o); define MEM_OOR_ERR_EN to complete out-of-range requests immediately with mem_err_o.
module mem_burst_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int MEM_WORDS  = 1024,
  parameter int LATENCY    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_req_i,
  input  logic                     mem_wr_i,
  input  logic [31:0]              mem_addr_i,
  input  logic [32*LINE_WORDS-1:0] mem_wdata_i,
  output logic                     mem_ready_o,
  output logic                     mem_valid_o,
  output logic [32*LINE_WORDS-1:0] mem_rdata_o,
  output logic                     mem_busy_o,
  output logic                     mem_err_o
);
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int LINE_W = IDX_W - OFF_W;
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT  = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;
  state_t state_q, state_d;

  logic                         wr_q, err_q;
  logic [LINE_W-1:0]            line_q;
  logic [OFF_W-1:0]             beat_q;
  logic [LAT_W-1:0]             lat_q;
  logic [LINE_WORDS-1:0][31:0]  wdata_q, rbuf_q, rbuf_d, rdata_q;
  logic [31:0]                  mem [MEM_WORDS];
  logic [IDX_W-1:0]             word_idx;
  logic                         oor, last_beat;
  logic                         unused_addr;

  assign last_beat = (beat_q == LAST_BEAT);
  assign word_idx  = {line_q, beat_q};

`ifdef MEM_OOR_ERR_EN
  assign oor         = |mem_addr_i[31:IDX_W+2];
  assign unused_addr = ^mem_addr_i[OFF_W+1:0];
`else
  // Upper address bits are dropped so the array aliases modulo MEM_WORDS.
  assign oor         = 1'b0;
  assign unused_addr = ^{mem_addr_i[31:IDX_W+2], mem_addr_i[OFF_W+1:0]};
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (mem_req_i) begin
          if (oor)               state_d = DONE;
          else if (LATENCY == 0) state_d = BURST;
          else                   state_d = WAIT;
        end
      end
      WAIT:    if (lat_q == '0) state_d = BURST;
      BURST:   if (last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Merge the current beat's word so the last beat can publish the full line.
  always_comb begin
    rbuf_d         = rbuf_q;
    rbuf_d[beat_q] = mem[word_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      line_q  <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (mem_req_i) begin
            wr_q    <= mem_wr_i;
            err_q   <= oor;
            line_q  <= mem_addr_i[IDX_W+1:OFF_W+2];
            beat_q  <= '0;
            lat_q   <= LAT_INIT;
            wdata_q <= mem_wdata_i;
          end
        end
        WAIT: lat_q <= lat_q - 1'b1;
        BURST: begin
          beat_q <= beat_q + 1'b1;
          if (!wr_q) begin
            rbuf_q <= rbuf_d;
            if (last_beat) rdata_q <= rbuf_d;
          end
        end
        DONE:    err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == BURST && wr_q) mem[word_idx] <= wdata_q[beat_q];
  end

  assign mem_ready_o = (state_q == IDLE);
  assign mem_busy_o  = (state_q != IDLE);
  assign mem_valid_o = (state_q == DONE);
  assign mem_err_o   = (state_q == DONE) && err_q;
  assign mem_rdata_o = rdata_q;
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Bench for mem_burst_ctrl: fixed vector table, hand-written reset/hold corner cases,
// and random traffic scored against a word-array reference model.
module tb_mem_burst_ctrl;
  localparam int LW      = 4;
  localparam int MW      = 1024;
  localparam int LAT     = 2;
  localparam int LINE_B  = 32 * LW;
  localparam int TXN_CYC = LAT + LW + 1;
  localparam int PERIOD  = LAT + LW + 2;
`ifdef MEM_OOR_ERR_EN
  localparam bit OOR_EN = 1'b1;
`else
  localparam bit OOR_EN = 1'b0;
`endif

  localparam logic [LINE_B-1:0] L1 = {32'h33333333, 32'h22222222, 32'h11111111, 32'hCAFEBABE};
  localparam logic [LINE_B-1:0] L2 = {32'h0D0D0D0D, 32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A};
  localparam logic [LINE_B-1:0] L3 = {32'hFFFF0003, 32'hFFFF0002, 32'hFFFF0001, 32'hFFFF0000};
  localparam logic [LINE_B-1:0] L4 = {32'h40400003, 32'h40400002, 32'h40400001, 32'h40400000};
  localparam logic [LINE_B-1:0] L5 = {32'h80800003, 32'h80800002, 32'h80800001, 32'h80800000};
  localparam logic [LINE_B-1:0] LA = {4{32'hAAAAAAAA}};

  logic              clk = 1'b0;
  logic              rst;
  logic              req, wr, ready, valid, busy, err;
  logic [31:0]       addr;
  logic [LINE_B-1:0] wdata, rdata;
  logic              req0, wr0, ready0, valid0, busy0, err0;
  logic [31:0]       addr0;
  logic [LINE_B-1:0] wdata0, rdata0;

  always #5 clk = ~clk;

  mem_burst_ctrl #(.LINE_WORDS(LW), .MEM_WORDS(MW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .mem_req_i(req), .mem_wr_i(wr), .mem_addr_i(addr),
    .mem_wdata_i(wdata), .mem_ready_o(ready), .mem_valid_o(valid),
    .mem_rdata_o(rdata), .mem_busy_o(busy), .mem_err_o(err));

  mem_burst_ctrl #(.LINE_WORDS(LW), .MEM_WORDS(MW), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .mem_req_i(req0), .mem_wr_i(wr0), .mem_addr_i(addr0),
    .mem_wdata_i(wdata0), .mem_ready_o(ready0), .mem_valid_o(valid0),
    .mem_rdata_o(rdata0), .mem_busy_o(busy0), .mem_err_o(err0));

  typedef struct {
    logic              wr;
    logic [31:0]       addr;
    logic [LINE_B-1:0] wdata;
    int                exp_lat;
    logic              exp_err;
    logic [LINE_B-1:0] exp_rd;
  } vec_t;
  vec_t tv [9];

  // Reference model: flat word array plus the last completed read line.
  logic [31:0]       ref_mem [MW];
  logic [LINE_B-1:0] last_rd;
  logic [31:0]       qline [$];
  int                n_cmp = 0;
  int                n_bad = 0;

  function automatic int line_base(input logic [31:0] a);
    return ((int'(a >> 2) % MW) / LW) * LW;
  endfunction

  function automatic bit is_oor(input logic [31:0] a);
    return OOR_EN && (a >= 32'(4 * MW));
  endfunction

  function automatic logic [LINE_B-1:0] ref_line(input logic [31:0] a);
    logic [LINE_B-1:0] l;
    int b;
    b = line_base(a);
    for (int k = 0; k < LW; k++) l[32*k +: 32] = ref_mem[b + k];
    return l;
  endfunction

  task automatic apply_model(input logic w, input logic [31:0] a, input logic [LINE_B-1:0] d);
    int b;
    if (is_oor(a)) return;
    b = line_base(a);
    if (w) begin
      for (int k = 0; k < LW; k++) ref_mem[b + k] = d[32*k +: 32];
      qline.push_back(32'(b * 4));
    end else begin
      last_rd = ref_line(a);
    end
  endtask

  task automatic chk(input string nm, input logic [LINE_B-1:0] act, input logic [LINE_B-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns cycles from acceptance edge to the valid pulse.
  task automatic do_txn(input logic w, input logic [31:0] a, input logic [LINE_B-1:0] d,
                        output int lat, output logic e, output logic [LINE_B-1:0] rd);
    int guard;
    guard = 0;
    lat = -1; e = 1'b0; rd = '0;
    while (!ready && guard < 50) begin @(negedge clk); guard++; end
    req = 1'b1; wr = w; addr = a; wdata = d;
    @(posedge clk);
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (n == 1) req = 1'b0;
      if (valid) begin lat = n; e = err; rd = rdata; break; end
    end
  endtask

  task automatic txn0(input logic w, input logic [31:0] a, input logic [LINE_B-1:0] d,
                      output int lat, output logic [LINE_B-1:0] rd);
    int guard;
    guard = 0;
    lat = -1; rd = '0;
    while (!ready0 && guard < 50) begin @(negedge clk); guard++; end
    req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d;
    @(posedge clk);
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (n == 1) req0 = 1'b0;
      if (valid0) begin lat = n; rd = rdata0; break; end
    end
  endtask

  task automatic model_txn(input logic w, input logic [31:0] a, input logic [LINE_B-1:0] d,
                           input string tag);
    int lat, exp_lat;
    logic e;
    logic [LINE_B-1:0] rd;
    exp_lat = is_oor(a) ? 1 : TXN_CYC;
    do_txn(w, a, d, lat, e, rd);
    apply_model(w, a, d);
    chk({tag, " latency"}, LINE_B'(lat), LINE_B'(exp_lat));
    chk({tag, " err"}, LINE_B'(e), LINE_B'(is_oor(a)));
    chk({tag, " rdata"}, rd, last_rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat, acc, run, max_low, vcnt;
    logic e;
    logic [LINE_B-1:0] rd;

    tv[0] = '{1'b1, 32'h0000_0C30, L1, TXN_CYC, 1'b0, '0};
    tv[1] = '{1'b0, 32'h0000_0C3C, '0, TXN_CYC, 1'b0, L1};
    tv[2] = '{1'b0, 32'h0000_1C30, '0, OOR_EN ? 1 : TXN_CYC, OOR_EN, L1};
    tv[3] = '{1'b1, 32'h0000_0000, L2, TXN_CYC, 1'b0, L1};
    tv[4] = '{1'b0, 32'h0000_0008, '0, TXN_CYC, 1'b0, L2};
    tv[5] = '{1'b0, 32'h0040_0000, '0, OOR_EN ? 1 : TXN_CYC, OOR_EN, L2};
    tv[6] = '{1'b1, 32'h0000_0FFC, L3, TXN_CYC, 1'b0, L2};
    tv[7] = '{1'b0, 32'h0000_0FF4, '0, TXN_CYC, 1'b0, L3};
    tv[8] = '{1'b1, 32'h0000_0040, L4, TXN_CYC, 1'b0, L3};

    rst = 1'b1;
    req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    req0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
    last_rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst ready", LINE_B'(ready), 1);
    chk("rst valid", LINE_B'(valid), 0);
    chk("rst busy", LINE_B'(busy), 0);
    chk("rst rdata", rdata, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst ready", LINE_B'(ready), 1);
    chk("post-rst busy", LINE_B'(busy), 0);
    chk("post-rst err", LINE_B'(err), 0);
    chk("post-rst err0", LINE_B'(err0), 0);

    for (int i = 0; i < 9; i++) begin
      do_txn(tv[i].wr, tv[i].addr, tv[i].wdata, lat, e, rd);
      chk($sformatf("vec%0d latency", i), LINE_B'(lat), LINE_B'(tv[i].exp_lat));
      chk($sformatf("vec%0d err", i), LINE_B'(e), LINE_B'(tv[i].exp_err));
      chk($sformatf("vec%0d rdata", i), rd, tv[i].exp_rd);
      apply_model(tv[i].wr, tv[i].addr, tv[i].wdata);
    end

    // Held request: one acceptance per PERIOD cycles, ready low in between.
    while (!ready) @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 32'h0000_0080; wdata = L5;
    acc = 0; run = 0; max_low = 0; vcnt = 0;
    for (int c = 0; c < 16; c++) begin
      if (valid) vcnt++;
      if (ready) begin acc++; run = 0; end
      else begin run++; if (run > max_low) max_low = run; end
      @(negedge clk);
    end
    req = 1'b0;
    chk("hold acceptances", LINE_B'(acc), LINE_B'((16 + PERIOD - 1) / PERIOD));
    chk("hold ready-low run", LINE_B'(max_low), LINE_B'(PERIOD - 1));
    chk("hold valid pulses", LINE_B'(vcnt), LINE_B'(acc));
    apply_model(1'b1, 32'h0000_0080, L5);

    // Reset during burst beat 2 of a write: beats 0-1 land, 2-3 keep old data.
    while (!ready) @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 32'h0000_0040; wdata = LA;
    @(posedge clk);
    for (int n = 1; n <= LAT + 3; n++) begin
      @(negedge clk);
      if (n == 1) req = 1'b0;
    end
    chk("mid-burst busy", LINE_B'(busy), 1);
    rst = 1'b1;
    #1;
    chk("mid-rst ready", LINE_B'(ready), 1);
    chk("mid-rst busy", LINE_B'(busy), 0);
    chk("mid-rst rdata", rdata, '0);
    @(negedge clk);
    rst = 1'b0;
    vcnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (valid) vcnt++;
      @(negedge clk);
    end
    chk("mid-rst no valid", LINE_B'(vcnt), 0);
    last_rd = '0;
    ref_mem[16] = 32'hAAAAAAAA;
    ref_mem[17] = 32'hAAAAAAAA;
    model_txn(1'b0, 32'h0000_0040, '0, "partial line read");
    chk("partial line const", last_rd, {L4[127:64], 64'hAAAAAAAA_AAAAAAAA});

    for (int i = 0; i < 60; i++) begin
      logic w;
      logic [31:0] a;
      logic [LINE_B-1:0] d;
      w = (qline.size() == 0) || ($urandom_range(0, 1) == 1);
      if (w) a = 32'($urandom_range(0, 4 * MW - 1));
      else   a = qline[$urandom_range(0, qline.size() - 1)] | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) a = a | (32'($urandom_range(1, 20'hFFFFF)) << 12);
      for (int k = 0; k < LW; k++) d[32*k +: 32] = $urandom;
      model_txn(w, a, d, $sformatf("rand%0d", i));
    end

    // Zero-latency instance: valid LINE_WORDS+1 cycles after acceptance.
    txn0(1'b1, 32'h0000_0000, L2, lat, rd);
    chk("lat0 write latency", LINE_B'(lat), LINE_B'(LW + 1));
    txn0(1'b0, 32'h0000_0000, '0, lat, rd);
    chk("lat0 read latency", LINE_B'(lat), LINE_B'(LW + 1));
    chk("lat0 read rdata", rd, L2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
